// File: rtl/wqe_receiver_if.sv
// rtl/wqe_receiver_if.sv - FIFO-side and WIT-side signal bundle for the WQE receiver
interface wqe_receiver_if #(
   parameter int WIT_ADDR_W = 14
);
   // metadata FIFO (FWFT)
   logic                  i_md_empty;
   logic                  o_md_rd_en;
   logic [255:0]          iv_md_data;
   // WQE segment FIFO (FWFT)
   logic                  i_wqe_empty;
   logic                  o_wqe_rd_en;
   logic [127:0]          iv_wqe_data;
   // header FIFO write side
   logic                  i_hdr_prog_full;
   logic                  o_hdr_wr_en;
   logic [383:0]          ov_hdr_data;
   // segment FIFO write side
   logic                  i_seg_prog_full;
   logic                  o_seg_wr_en;
   logic [128:0]          ov_seg_data;
   // WQE indicator table write port
   logic                  o_wit_wr_en;
   logic [WIT_ADDR_W-1:0] ov_wit_wr_addr;
   logic                  ov_wit_wr_data;
   // zero-length WQE indication
   logic                  o_err_pulse;

   // receiver side
   modport slave (
      input  i_md_empty, iv_md_data, i_wqe_empty, iv_wqe_data,
             i_hdr_prog_full, i_seg_prog_full,
      output o_md_rd_en, o_wqe_rd_en, o_hdr_wr_en, ov_hdr_data,
             o_seg_wr_en, ov_seg_data, o_wit_wr_en, ov_wit_wr_addr,
             ov_wit_wr_data, o_err_pulse
   );

   // FIFO / table environment side
   modport master (
      output i_md_empty, iv_md_data, i_wqe_empty, iv_wqe_data,
             i_hdr_prog_full, i_seg_prog_full,
      input  o_md_rd_en, o_wqe_rd_en, o_hdr_wr_en, ov_hdr_data,
             o_seg_wr_en, ov_seg_data, o_wit_wr_en, ov_wit_wr_addr,
             ov_wit_wr_data, o_err_pulse
   );
endinterface

// File: rtl/wqe_receiver.sv
// rtl/wqe_receiver.sv - WQE parser front end: metadata/segment FIFO consumer, header/segment writer, WIT updater (optional counters: WQE_RECEIVER_STATS_EN)
module wqe_receiver #(
   parameter int WIT_ADDR_W = 14,
   parameter int STAT_W     = 32
) (
   input  logic        clk,
   input  logic        rst,
   wqe_receiver_if.slave bus,
   input  logic [31:0] dbg_sel,
   output logic [31:0] dbg_bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEG  = 1'b1
   } state_t;

   state_t state_q, state_d;

   // combinational pops
   logic md_rd;
   logic wqe_rd;

   // registered write-side outputs
   logic                  hdr_wr_q, hdr_wr_d;
   logic [383:0]          hdr_data_q, hdr_data_d;
   logic                  seg_wr_q, seg_wr_d;
   logic [128:0]          seg_data_q, seg_data_d;
   logic                  wit_wr_q, wit_wr_d;
   logic [WIT_ADDR_W-1:0] wit_addr_q, wit_addr_d;
   logic                  wit_data_q, wit_data_d;
   logic                  err_q, err_d;

   // per-WQE context latched at header time
   logic [15:0]           remaining_q, remaining_d;
   logic [9:0]            qpn_q, qpn_d;
   logic                  pend_q, pend_d;

   logic [15:0] md_total;
   logic [9:0]  md_qpn;
   logic        md_pend;
   logic        start_ok;
   logic        zero_len;
   logic        seg_ok;
   logic        last_seg;

   assign md_total = bus.iv_md_data[175:160];
   assign md_qpn   = bus.iv_md_data[17:8];
   assign md_pend  = bus.iv_md_data[7];

   // A WQE may only start when both downstream FIFOs can absorb its first writes;
   // a zero-length descriptor is dropped regardless of downstream space.
   assign start_ok = !bus.i_md_empty && !bus.i_wqe_empty && !bus.i_hdr_prog_full &&
                     !bus.i_seg_prog_full && (md_total != 16'd0);
   assign zero_len = !bus.i_md_empty && (md_total == 16'd0);
   assign seg_ok   = !bus.i_wqe_empty && !bus.i_seg_prog_full;
   assign last_seg = (remaining_q == 16'd1);

   // State register and all datapath flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hdr_wr_q    <= 1'b0;
         hdr_data_q  <= '0;
         seg_wr_q    <= 1'b0;
         seg_data_q  <= '0;
         wit_wr_q    <= 1'b0;
         wit_addr_q  <= '0;
         wit_data_q  <= 1'b0;
         err_q       <= 1'b0;
         remaining_q <= '0;
         qpn_q       <= '0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_wr_q    <= hdr_wr_d;
         hdr_data_q  <= hdr_data_d;
         seg_wr_q    <= seg_wr_d;
         seg_data_q  <= seg_data_d;
         wit_wr_q    <= wit_wr_d;
         wit_addr_q  <= wit_addr_d;
         wit_data_q  <= wit_data_d;
         err_q       <= err_d;
         remaining_q <= remaining_d;
         qpn_q       <= qpn_d;
         pend_q      <= pend_d;
      end
   end

   // Next state: single-segment WQEs never leave IDLE, so back-to-back total==1 WQEs cost one cycle each
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_ok && (md_total != 16'd1)) state_d = S_SEG;
         S_SEG:  if (seg_ok && last_seg)              state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO pops: combinational so the FWFT head is consumed in the cycle it is used; held off during reset
   always_comb begin
      md_rd  = 1'b0;
      wqe_rd = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  md_rd  = 1'b1;
                  wqe_rd = 1'b1;
               end else if (zero_len) begin
                  md_rd  = 1'b1;
               end
            end
            S_SEG:   wqe_rd = seg_ok;
            default: ;
         endcase
      end
   end

   // Write-side next values: strobes are one-cycle, data registers hold between writes
   always_comb begin
      hdr_wr_d    = 1'b0;
      hdr_data_d  = hdr_data_q;
      seg_wr_d    = 1'b0;
      seg_data_d  = seg_data_q;
      wit_wr_d    = 1'b0;
      wit_addr_d  = wit_addr_q;
      wit_data_d  = wit_data_q;
      err_d       = 1'b0;
      remaining_d = remaining_q;
      qpn_d       = qpn_q;
      pend_d      = pend_q;
      if (state_q == S_IDLE && md_rd && wqe_rd) begin
         hdr_wr_d    = 1'b1;
         hdr_data_d  = {bus.iv_md_data, bus.iv_wqe_data};
         remaining_d = md_total - 16'd1;
         qpn_d       = md_qpn;
         pend_d      = md_pend;
         if (md_total == 16'd1) begin
            wit_wr_d   = 1'b1;
            wit_addr_d = {{(WIT_ADDR_W-10){1'b0}}, md_qpn};
            wit_data_d = md_pend;
         end
      end else if (state_q == S_IDLE && md_rd) begin
         err_d = 1'b1;
      end else if (state_q == S_SEG && wqe_rd) begin
         seg_wr_d    = 1'b1;
         seg_data_d  = {last_seg, bus.iv_wqe_data};
         remaining_d = remaining_q - 16'd1;
         if (last_seg) begin
            wit_wr_d   = 1'b1;
            wit_addr_d = {{(WIT_ADDR_W-10){1'b0}}, qpn_q};
            wit_data_d = pend_q;
         end
      end
   end

   assign bus.o_md_rd_en     = md_rd;
   assign bus.o_wqe_rd_en    = wqe_rd;
   assign bus.o_hdr_wr_en    = hdr_wr_q;
   assign bus.ov_hdr_data    = hdr_data_q;
   assign bus.o_seg_wr_en    = seg_wr_q;
   assign bus.ov_seg_data    = seg_data_q;
   assign bus.o_wit_wr_en    = wit_wr_q;
   assign bus.ov_wit_wr_addr = wit_addr_q;
   assign bus.ov_wit_wr_data = wit_data_q;
   assign bus.o_err_pulse    = err_q;

`ifdef WQE_RECEIVER_STATS_EN
   logic [STAT_W-1:0] stat_wqe_q, stat_wqe_d;
   logic [STAT_W-1:0] stat_seg_q, stat_seg_d;
   logic [STAT_W-1:0] stat_err_q, stat_err_d;

   // Statistics counters, free-running and wrapping, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_wqe_q <= '0;
         stat_seg_q <= '0;
         stat_err_q <= '0;
      end else begin
         stat_wqe_q <= stat_wqe_d;
         stat_seg_q <= stat_seg_d;
         stat_err_q <= stat_err_d;
      end
   end

   // A WQE completes exactly when its WIT write is issued
   always_comb begin
      stat_wqe_d = stat_wqe_q + (wit_wr_d ? STAT_W'(1) : STAT_W'(0));
      stat_seg_d = stat_seg_q + (seg_wr_d ? STAT_W'(1) : STAT_W'(0));
      stat_err_d = stat_err_q + (err_d    ? STAT_W'(1) : STAT_W'(0));
   end
`endif

   // Debug read mux
   always_comb begin
      dbg_bus = 32'd0;
      case (dbg_sel)
         32'd0: dbg_bus = {26'd0, md_rd, wqe_rd, hdr_wr_q, seg_wr_q, wit_wr_q, err_q};
         32'd1: dbg_bus = {31'd0, state_q};
         32'd2: dbg_bus = {16'd0, remaining_q};
         32'd3: dbg_bus = {22'd0, qpn_q};
`ifdef WQE_RECEIVER_STATS_EN
         32'd4: dbg_bus = 32'(stat_wqe_q);
         32'd5: dbg_bus = 32'(stat_seg_q);
         32'd6: dbg_bus = 32'(stat_err_q);
`endif
         default: dbg_bus = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_wqe_receiver.sv
// tb/tb_wqe_receiver.sv - scoreboard bench for wqe_receiver with FWFT FIFO models
module tb_wqe_receiver;

   logic        clk;
   logic        rst;
   logic [31:0] dbg_sel;
   logic [31:0] dbg_bus;

   wqe_receiver_if #(.WIT_ADDR_W(14)) w();

   wqe_receiver #(.WIT_ADDR_W(14), .STAT_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (w),
      .dbg_sel (dbg_sel),
      .dbg_bus (dbg_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO contents and scoreboard
   logic [255:0] md_q[$];
   logic [127:0] wq_q[$];
   logic [383:0] exp_hdr[$];
   logic [128:0] exp_seg[$];
   logic [14:0]  exp_wit[$];
   int           exp_err;
   logic [128:0] last_seg_exp;

   int cyc;
   int n_hdr, n_seg, n_wit, n_err, n_md_pop, n_wqe_pop;
   int hdr_cyc[$], seg_cyc[$], wit_cyc[$];
   int md_pop_cyc;
   logic last_pm, last_pw;

   int n_chk;
   int n_fail;

   task automatic refresh();
      w.i_md_empty  = (md_q.size() == 0);
      w.iv_md_data  = (md_q.size() != 0) ? md_q[0] : '0;
      w.i_wqe_empty = (wq_q.size() == 0);
      w.iv_wqe_data = (wq_q.size() != 0) ? wq_q[0] : '0;
   endtask

   task automatic clear_counts();
      n_hdr = 0; n_seg = 0; n_wit = 0; n_err = 0; n_md_pop = 0; n_wqe_pop = 0;
      hdr_cyc.delete(); seg_cyc.delete(); wit_cyc.delete();
      md_pop_cyc = -1;
   endtask

   task automatic push_wqe(input int total, input logic [9:0] qpn, input logic pend);
      logic [255:0] md;
      logic [127:0] s;
      for (int i = 0; i < 8; i++) md[i*32 +: 32] = $urandom;
      md[175:160] = total[15:0];
      md[17:8]    = qpn;
      md[7]       = pend;
      md_q.push_back(md);
      if (total == 0) exp_err++;
      for (int i = 0; i < total; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         wq_q.push_back(s);
         if (i == 0) begin
            exp_hdr.push_back({md, s});
         end else begin
            last_seg_exp = {(i == total - 1), s};
            exp_seg.push_back(last_seg_exp);
         end
      end
      if (total != 0) exp_wit.push_back({4'b0000, qpn, pend});
      refresh();
   endtask

   // One clock: entered and left at a falling edge. Captures pops just before the
   // rising edge, applies them to the FIFO models, then scores the DUT writes.
   task automatic tick();
      logic [383:0] eh;
      logic [128:0] es;
      logic [14:0]  ew;
      #4;
      last_pm = w.o_md_rd_en;
      last_pw = w.o_wqe_rd_en;
      if (last_pm) md_pop_cyc = cyc;
      @(posedge clk);
      cyc++;
      #1;
      if (last_pm && md_q.size() != 0) begin md_q.pop_front(); n_md_pop++; end
      if (last_pw && wq_q.size() != 0) begin wq_q.pop_front(); n_wqe_pop++; end
      refresh();
      @(negedge clk);
      if (w.o_hdr_wr_en) begin
         n_hdr++; hdr_cyc.push_back(cyc);
         n_chk++;
         if (exp_hdr.size() == 0) begin
            n_fail++; $display("FAIL hdr_unexpected: got %h, required none", w.ov_hdr_data);
         end else begin
            eh = exp_hdr.pop_front();
            if (w.ov_hdr_data !== eh) begin
               n_fail++; $display("FAIL hdr_data: got %h, required %h", w.ov_hdr_data, eh);
            end
         end
      end
      if (w.o_seg_wr_en) begin
         n_seg++; seg_cyc.push_back(cyc);
         n_chk++;
         if (exp_seg.size() == 0) begin
            n_fail++; $display("FAIL seg_unexpected: got %h, required none", w.ov_seg_data);
         end else begin
            es = exp_seg.pop_front();
            if (w.ov_seg_data !== es) begin
               n_fail++; $display("FAIL seg_data: got %h, required %h", w.ov_seg_data, es);
            end
         end
      end
      if (w.o_wit_wr_en) begin
         n_wit++; wit_cyc.push_back(cyc);
         n_chk++;
         if (exp_wit.size() == 0) begin
            n_fail++; $display("FAIL wit_unexpected: got %h/%b, required none", w.ov_wit_wr_addr, w.ov_wit_wr_data);
         end else begin
            ew = exp_wit.pop_front();
            if ({w.ov_wit_wr_addr, w.ov_wit_wr_data} !== ew) begin
               n_fail++; $display("FAIL wit_write: got %h, required %h", {w.ov_wit_wr_addr, w.ov_wit_wr_data}, ew);
            end
         end
         n_chk++;
         if (!(w.o_hdr_wr_en || (w.o_seg_wr_en && w.ov_seg_data[128]))) begin
            n_fail++; $display("FAIL wit_timing: got wit without final write (hdr=%b seg=%b), required coincident", w.o_hdr_wr_en, w.o_seg_wr_en);
         end
      end
      if (w.o_err_pulse) begin
         n_err++;
         n_chk++;
         if (exp_err == 0) begin
            n_fail++; $display("FAIL err_unexpected: got 1, required 0");
         end else begin
            exp_err--;
         end
      end
   endtask

   task automatic drain(input string name);
      int b;
      b = 0;
      while ((exp_hdr.size() != 0 || exp_seg.size() != 0 || exp_wit.size() != 0 || exp_err != 0) && b < 200) begin
         tick();
         b++;
      end
      n_chk++;
      if (b >= 200) begin
         n_fail++; $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_hdr.size() + exp_seg.size() + exp_wit.size() + exp_err);
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++; if (w.o_hdr_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_hdr_wr: got %b, required 0", w.o_hdr_wr_en); end
      n_chk++; if (w.o_seg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_seg_wr: got %b, required 0", w.o_seg_wr_en); end
      n_chk++; if (w.o_wit_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wit_wr: got %b, required 0", w.o_wit_wr_en); end
      n_chk++; if (w.o_err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", w.o_err_pulse); end
      n_chk++; if (w.ov_hdr_data !== '0) begin n_fail++; $display("FAIL rst_hdr_data: got %h, required 0", w.ov_hdr_data); end
      n_chk++; if (w.ov_wit_wr_addr !== '0) begin n_fail++; $display("FAIL rst_wit_addr: got %h, required 0", w.ov_wit_wr_addr); end
      dbg_sel = 32'd1;
      #1;
      n_chk++; if (dbg_bus !== 32'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0", dbg_bus); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      clear_counts();
      push_wqe(1, 10'h02A, 1'b1);
      drain("single");
      n_chk++; if (hdr_cyc.size() != 1 || hdr_cyc[0] != md_pop_cyc + 1) begin n_fail++; $display("FAIL single_hdr_latency: got %0d, required %0d", hdr_cyc.size() ? hdr_cyc[0] : -1, md_pop_cyc + 1); end
      n_chk++; if (wit_cyc.size() != 1 || wit_cyc[0] != hdr_cyc[0]) begin n_fail++; $display("FAIL single_wit_cycle: got %0d, required %0d", wit_cyc.size() ? wit_cyc[0] : -1, hdr_cyc[0]); end
      n_chk++; if (n_seg != 0) begin n_fail++; $display("FAIL single_seg_count: got %0d, required 0", n_seg); end
      n_chk++; if (w.ov_wit_wr_addr !== 14'h002A || w.ov_wit_wr_data !== 1'b1) begin n_fail++; $display("FAIL single_wit_hold: got %h/%b, required 002a/1", w.ov_wit_wr_addr, w.ov_wit_wr_data); end
   endtask

   task automatic test_multi();
      clear_counts();
      push_wqe(4, 10'h155, 1'b0);
      drain("multi");
      n_chk++; if (n_seg != 3) begin n_fail++; $display("FAIL multi_seg_count: got %0d, required 3", n_seg); end
      n_chk++; if (seg_cyc[0] != hdr_cyc[0] + 1 || seg_cyc[1] != seg_cyc[0] + 1 || seg_cyc[2] != seg_cyc[1] + 1) begin n_fail++; $display("FAIL multi_seg_spacing: got %0d %0d %0d after hdr %0d, required consecutive", seg_cyc[0], seg_cyc[1], seg_cyc[2], hdr_cyc[0]); end
      n_chk++; if (n_wit != 1 || wit_cyc[0] != seg_cyc[2]) begin n_fail++; $display("FAIL multi_wit_cycle: got %0d (n=%0d), required %0d", wit_cyc[0], n_wit, seg_cyc[2]); end
      n_chk++; if (w.ov_seg_data !== last_seg_exp) begin n_fail++; $display("FAIL multi_seg_hold: got %h, required %h", w.ov_seg_data, last_seg_exp); end
   endtask

   task automatic test_stall();
      int b;
      int pops;
      clear_counts();
      push_wqe(3, 10'h0F0, 1'b1);
      b = 0;
      while (n_hdr == 0 && b < 50) begin tick(); b++; end
      w.i_seg_prog_full = 1'b1;
      pops = n_wqe_pop;
      repeat (5) tick();
      n_chk++; if (n_wqe_pop != pops) begin n_fail++; $display("FAIL stall_pops: got %0d, required 0", n_wqe_pop - pops); end
      n_chk++; if (n_seg != 0) begin n_fail++; $display("FAIL stall_seg_writes: got %0d, required 0", n_seg); end
      w.i_seg_prog_full = 1'b0;
      drain("stall");
      n_chk++; if (n_seg != 2) begin n_fail++; $display("FAIL stall_seg_count: got %0d, required 2", n_seg); end
   endtask

   task automatic test_zero_len();
      clear_counts();
      push_wqe(0, 10'h011, 1'b1);
      push_wqe(2, 10'h022, 1'b1);
      tick();
      n_chk++; if (last_pm !== 1'b1 || last_pw !== 1'b0) begin n_fail++; $display("FAIL zero_pops: got md=%b wqe=%b, required md=1 wqe=0", last_pm, last_pw); end
      drain("zero");
      n_chk++; if (n_err != 1) begin n_fail++; $display("FAIL zero_err_count: got %0d, required 1", n_err); end
      n_chk++; if (n_md_pop != 2 || n_wqe_pop != 2) begin n_fail++; $display("FAIL zero_pop_counts: got md=%0d wqe=%0d, required 2/2", n_md_pop, n_wqe_pop); end
      n_chk++; if (n_hdr != 1 || n_seg != 1 || n_wit != 1) begin n_fail++; $display("FAIL zero_follow: got hdr=%0d seg=%0d wit=%0d, required 1/1/1", n_hdr, n_seg, n_wit); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      push_wqe(2, 10'h101, 1'b0);
      push_wqe(1, 10'h202, 1'b1);
      drain("b2b");
      n_chk++; if (n_hdr != 2 || hdr_cyc[1] != seg_cyc[0] + 1) begin n_fail++; $display("FAIL b2b_hdr_cycle: got %0d, required %0d", hdr_cyc[1], seg_cyc[0] + 1); end
      n_chk++; if (n_wit != 2 || wit_cyc[1] != wit_cyc[0] + 1) begin n_fail++; $display("FAIL b2b_wit_cycles: got %0d,%0d, required consecutive", wit_cyc[0], wit_cyc[1]); end
   endtask

   task automatic test_reset_mid();
      int b;
      clear_counts();
      push_wqe(7, 10'h3A5, 1'b1);
      b = 0;
      while (n_seg == 0 && b < 50) begin tick(); b++; end
      dbg_sel = 32'd2;
      #1;
      n_chk++; if (dbg_bus !== 32'd5) begin n_fail++; $display("FAIL mid_remaining: got %0d, required 5", dbg_bus); end
      dbg_sel = 32'd3;
      #1;
      n_chk++; if (dbg_bus !== 32'h3A5) begin n_fail++; $display("FAIL mid_qpn: got %h, required 3a5", dbg_bus); end
      rst = 1'b1;
      #1;
      n_chk++; if ({w.o_hdr_wr_en, w.o_seg_wr_en, w.o_wit_wr_en, w.o_wqe_rd_en} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_outputs: got %b, required 0000", {w.o_hdr_wr_en, w.o_seg_wr_en, w.o_wit_wr_en, w.o_wqe_rd_en}); end
      n_chk++; if (w.ov_seg_data !== '0) begin n_fail++; $display("FAIL mid_rst_seg_data: got %h, required 0", w.ov_seg_data); end
      md_q.delete(); wq_q.delete(); exp_hdr.delete(); exp_seg.delete(); exp_wit.delete(); exp_err = 0;
      refresh();
      @(negedge clk);
      tick();
      n_chk++; if (n_wit != 0) begin n_fail++; $display("FAIL mid_rst_wit: got %0d, required 0", n_wit); end
      for (int s = 4; s <= 6; s++) begin
         dbg_sel = s;
         #1;
         n_chk++; if (dbg_bus !== 32'd0) begin n_fail++; $display("FAIL mid_rst_stat%0d: got %0d, required 0", s, dbg_bus); end
      end
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
      push_wqe(2, 10'h3FF, 1'b1);
      drain("after_rst");
      n_chk++; if (n_hdr != 1 || n_seg != 1 || n_wit != 1) begin n_fail++; $display("FAIL after_rst_counts: got hdr=%0d seg=%0d wit=%0d, required 1/1/1", n_hdr, n_seg, n_wit); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; exp_err = 0;
      last_seg_exp = '0; last_pm = 1'b0; last_pw = 1'b0;
      rst = 1'b1;
      dbg_sel = 32'd0;
      w.i_hdr_prog_full = 1'b0;
      w.i_seg_prog_full = 1'b0;
      clear_counts();
      refresh();
      @(negedge clk);
      test_reset();
      test_single();
      test_multi();
      test_stall();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wqe_receiver.md
Name: wqe_receiver

Overview:
- WQE Parser front end; the consuming end of the scheduler→parser metadata/WQE FIFO pair.
- Pops one 256b metadata word plus its 16B WQE segments, then emits one header record (metadata + first segment) and a tagged segment stream.
- On WQE completion, writes the per-QP pending bit into the WQE Indicator Table (WIT).

Parameters:
- WIT_ADDR_W, 14, WIT address width; QPN index is zero-extended to this width.
- STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- i_md_empty  input  1  metadata FIFO empty (first-word-fall-through, FWFT)
- o_md_rd_en  output  1  metadata FIFO pop
- iv_md_data  input  256  metadata; [175:160] WQE 16B count; [17:8] QPN index; [7] more-WQE-pending flag
- i_wqe_empty  input  1  WQE segment FIFO empty (FWFT)
- o_wqe_rd_en  output  1  WQE segment FIFO pop
- iv_wqe_data  input  128  WQE segment
- i_hdr_prog_full  input  1  header FIFO programmable-full
- o_hdr_wr_en  output  1  header write
- ov_hdr_data  output  384  {metadata, first segment}
- i_seg_prog_full  input  1  segment FIFO programmable-full
- o_seg_wr_en  output  1  segment write
- ov_seg_data  output  129  {last, segment}
- o_wit_wr_en  output  1  WIT write strobe
- ov_wit_wr_addr  output  WIT_ADDR_W  WIT index
- ov_wit_wr_data  output  1  pending bit
- o_err_pulse  output  1  zero-length WQE detected
- dbg_sel  input  32  debug select
- dbg_bus  output  32  debug data

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: all registered outputs 0; state IDLE; counters 0. Reset mid-WQE abandons the WQE; no WIT write.
- Pop signals: `o_md_rd_en` and `o_wqe_rd_en` are combinational from state and flags. Writes are registered, one cycle after the pop.
- States: IDLE, SEG.
- IDLE, start condition: !i_md_empty && !i_wqe_empty && !i_hdr_prog_full && !i_seg_prog_full, with total = iv_md_data[175:160] != 0.
  - Pop both FIFOs.
  - Next cycle: o_hdr_wr_en=1, ov_hdr_data = {md, wqe}.
  - Latch remaining = total-1 (16b), latch QPN and pending flag.
  - If total==1: WIT write in the same cycle as the header write, then stay IDLE.
  - Otherwise go to SEG.
- IDLE with total==0 and !i_md_empty: pop metadata only, do not pop the WQE FIFO. Next cycle o_err_pulse=1; stay IDLE.
- SEG: pop when !i_wqe_empty && !i_seg_prog_full.
  - Next cycle: o_seg_wr_en=1, ov_seg_data = {remaining==1, wqe}.
  - Decrement remaining on each pop.
  - On the pop with remaining==1, return to IDLE; WIT write is in the cycle of the last segment write.
  - Stall indefinitely otherwise; no timeouts.
- WIT write:
  - ov_wit_wr_addr = zero-extended md[17:8]
  - ov_wit_wr_data = md[7]
  - o_wit_wr_en is a single-cycle pulse.
- Back-to-back WQEs: IDLE may start a new WQE in the cycle after the last SEG pop. Minimum cost is 1 cycle per segment plus 1 cycle per WQE; no extra bubble for total==1.
- Registered data outputs hold their last value when the write enable is 0.
- dbg_bus:
  - sel 0: {rd/wr enables}
  - sel 1: state
  - sel 2: remaining
  - sel 3: latched QPN
  - others: 0

Optional Feature:
- Macro WQE_RECEIVER_STATS_EN.
- Defined:
  - STAT_W-bit wrapping counters for WQEs completed, segments forwarded and zero-length errors.
  - Readable on dbg_sel 4/5/6.
  - Cleared only by rst.
- Undefined: no counters; dbg_sel 4–6 return 0.

Test Plan:
- Single WQE, total=1, QPN index 0x2A, md[7]=1 → pops at cycle 0; cycle 1: hdr_wr_en=1, wit_wr_en=1, addr=0x002A, data=1; no seg write.
- total=4, md[7]=0, segments always available → 3 seg writes on consecutive cycles, last bit only on the third; WIT data=0 coincident with the third write.
- total=3 with i_seg_prog_full asserted for 5 cycles mid-WQE → no pops while full; segment order is preserved; exactly 2 seg writes; the last bit is correct.
- total=0 metadata followed by total=2 WQE → first: err_pulse=1, only md popped, WQE FIFO untouched; second processes normally.
- Two WQEs back-to-back (total 2 then 1) → no idle cycle between; second header write occurs the cycle after the first WQE's last seg write.
- rst asserted mid-SEG with remaining=5 → outputs 0 immediately, no WIT write; after release the next md is processed from IDLE. With WQE_RECEIVER_STATS_EN, counters read 0.
